// File: rtl/div_share_ctrl.sv
// Shares one combinational signed divider between two requesters. Operands are
// registered and held for SETTLE cycles before the quotient is captured.
module div_share_ctrl #(
  parameter int N      = 32,
  parameter int SETTLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_dividend,
  input  logic [N-1:0] req0_divisor,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [N-1:0] resp0_quotient,
  output logic         resp0_dbz,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_dividend,
  input  logic [N-1:0] req1_divisor,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp1_quotient,
  output logic         resp1_dbz,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic [N-1:0] div_quotient,
  output logic         busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg;
  logic                owner_reg, owner_next;
  logic                last_grant_reg;
  logic [1:0]          req_valid, resp_ready, grant, accept;
  logic [1:0]          resp_valid_reg, resp_valid_next;
  logic                busy_reg, busy_next;
  logic [1:0][N-1:0]   quotient_w;
  logic [1:0]          dbz_w;
  logic                sel_port, sel_zero, settle_done;
  logic [N-1:0]        sel_dividend, sel_divisor;
  logic [N-1:0]        div_dividend_reg, div_divisor_reg;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};

  // Round-robin on contention: the port that did not win last time goes first.
  always_comb begin
    grant[0] = req_valid[0] & (~req_valid[1] | last_grant_reg);
    grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant_reg);
  end

  assign accept       = (state_reg == ST_IDLE) ? grant : 2'b00;
  assign req0_ready   = accept[0];
  assign req1_ready   = accept[1];
  assign sel_port     = grant[1];
  assign sel_dividend = sel_port ? req1_dividend : req0_dividend;
  assign sel_divisor  = sel_port ? req1_divisor : req0_divisor;
  assign sel_zero     = (sel_divisor == '0);
  assign settle_done  = (state_reg == ST_SETTLE) && (count_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|accept) begin
          state_next = sel_zero ? ST_RESP : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (count_reg == '0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready[owner_reg]) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_next         = (|accept) ? sel_port : owner_reg;
    busy_next          = (state_next != ST_IDLE);
    resp_valid_next[0] = (state_next == ST_RESP) && !owner_next;
    resp_valid_next[1] = (state_next == ST_RESP) && owner_next;
  end

  // Divider operands move only on an accept, keeping the multicycle path stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_reg   <= 2'b00;
      busy_reg         <= 1'b0;
      owner_reg        <= 1'b0;
      last_grant_reg   <= 1'b1;
      count_reg        <= '0;
      div_dividend_reg <= '0;
      div_divisor_reg  <= '0;
    end else begin
      resp_valid_reg <= resp_valid_next;
      busy_reg       <= busy_next;
      owner_reg      <= owner_next;
      if (|accept) begin
        last_grant_reg   <= sel_port;
        div_dividend_reg <= sel_dividend;
        div_divisor_reg  <= sel_divisor;
        count_reg        <= CW'(SETTLE - 1);
      end else if ((state_reg == ST_SETTLE) && (count_reg != '0)) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [N-1:0] quotient_reg;
      logic         dbz_reg;

      // A zero divisor answers immediately; the divider output is never looked at.
      always_ff @(posedge clk) begin
        if (reset) begin
          quotient_reg <= '0;
          dbz_reg      <= 1'b0;
        end else if (accept[gi] && sel_zero) begin
          quotient_reg <= '0;
          dbz_reg      <= 1'b1;
        end else if (settle_done && (owner_reg == 1'(gi))) begin
          quotient_reg <= div_quotient;
          dbz_reg      <= 1'b0;
        end
      end

      assign quotient_w[gi] = quotient_reg;
      assign dbz_w[gi]      = dbz_reg;
    end
  endgenerate

  assign resp0_valid    = resp_valid_reg[0];
  assign resp1_valid    = resp_valid_reg[1];
  assign resp0_quotient = quotient_w[0];
  assign resp1_quotient = quotient_w[1];
  assign resp0_dbz      = dbz_w[0];
  assign resp1_dbz      = dbz_w[1];
  assign div_dividend   = div_dividend_reg;
  assign div_divisor    = div_divisor_reg;
  assign busy           = busy_reg;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_div_share_ctrl;
  localparam int N      = 32;
  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_dbz;
  logic         req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_dbz;
  logic [N-1:0] req0_dividend, req0_divisor, resp0_quotient;
  logic [N-1:0] req1_dividend, req1_divisor, resp1_quotient;
  logic [N-1:0] div_dividend, div_divisor, div_quotient;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_quotient(resp0_quotient), .resp0_dbz(resp0_dbz),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_quotient(resp1_quotient), .resp1_dbz(resp1_dbz),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .busy(busy)
  );

  // Divider model: only produces the true quotient once operands have been
  // steady for SETTLE cycles; a zero divisor yields a poison value.
  logic [N-1:0] prev_dd = '0;
  logic [N-1:0] prev_dv = '0;
  int age_reg = 0;
  int eff_age;
  always_comb begin
    eff_age = ((div_dividend !== prev_dd) || (div_divisor !== prev_dv)) ? 1 : age_reg + 1;
    if (div_divisor == '0) div_quotient = 32'hDEAD_BEEF;
    else if (eff_age < SETTLE) div_quotient = 32'h0BAD_0BAD;
    else div_quotient = 32'($signed(div_dividend) / $signed(div_divisor));
  end
  always @(posedge clk) begin
    prev_dd <= div_dividend;
    prev_dv <= div_divisor;
    age_reg <= (eff_age > 1000) ? 1000 : eff_age;
  end

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? req1_ready : req0_ready;
  endfunction
  function automatic logic rv(input int p);
    return (p == 1) ? resp1_valid : resp0_valid;
  endfunction
  function automatic logic [31:0] rq(input int p);
    return (p == 1) ? resp1_quotient : resp0_quotient;
  endfunction
  function automatic logic rd(input int p);
    return (p == 1) ? resp1_dbz : resp0_dbz;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (p == 1) begin
      req1_valid = v; req1_dividend = a; req1_divisor = b;
    end else begin
      req0_valid = v; req0_dividend = a; req0_divisor = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input int p, output int cycles);
    cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rv(p)) begin
        cycles = k;
        break;
      end
    end
    chk_b({nm, " resp_seen"}, (cycles != 0), 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk_b({nm, " idle_reached"}, (ok != 0), 1'b1);
  endtask

  // One isolated request with resp_ready held high; checks latency and result.
  task automatic run_one(input string nm, input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic ed, input int el);
    int lat;
    lat = 0;
    @(negedge clk);
    set_req(p, 1'b1, a, b);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    #1;
    chk_b({nm, " ready"}, rdy(p), 1'b1);
    chk_b({nm, " other_ready"}, rdy(1 - p), 1'b0);
    @(posedge clk);
    #1;
    set_req(p, 1'b0, $urandom, $urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk_b({nm, " busy"}, busy, 1'b1);
      chk_b({nm, " other_resp"}, rv(1 - p), 1'b0);
      if (rv(p)) begin
        lat = k;
        break;
      end
    end
    chk_i({nm, " latency"}, lat, el);
    chk_w({nm, " quotient"}, rq(p), eq);
    chk_b({nm, " dbz"}, rd(p), ed);
    $display("txn %s port=%0d %h/%h -> q=%h dbz=%b lat=%0d", nm, p, a, b, rq(p), rd(p), lat);
    @(negedge clk);
    chk_b({nm, " resp_dropped"}, rv(p), 1'b0);
    chk_b({nm, " busy_dropped"}, busy, 1'b0);
  endtask

  typedef struct {
    string       nm;
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int acc_port[3], acc_cyc[3], nacc;
    int resp_port[4], nresp;
    logic [31:0] resp_q[4];
    int cyc_n;
    logic m_busy, m_last, m_dbz, er0, er1, ev0, ev1;
    int m_resp, m_owner, txn, p;
    logic [31:0] m_a, m_b, m_q, ra, rb;

    reset = 1'b1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk_b("reset resp0_valid", resp0_valid, 1'b0);
    chk_b("reset resp1_valid", resp1_valid, 1'b0);
    chk_w("reset resp0_q", resp0_quotient, 32'h0);
    chk_b("reset resp1_dbz", resp1_dbz, 1'b0);
    chk_w("reset div_dividend", div_dividend, 32'h0);
    chk_w("reset div_divisor", div_divisor, 32'h0);
    chk_b("reset busy", busy, 1'b0);
    chk_b("reset req0_ready", req0_ready, 1'b0);

    vecs[0] = '{"p0_12_4",     0, 32'd12,         32'd4,          32'd3,          1'b0, SETTLE + 1};
    vecs[1] = '{"p1_m7_2",     1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, SETTLE + 1};
    vecs[2] = '{"p0_55_0",     0, 32'd55,         32'd0,          32'd0,          1'b1, 1};
    vecs[3] = '{"p1_8_2",      1, 32'd8,          32'd2,          32'd4,          1'b0, SETTLE + 1};
    vecs[4] = '{"p0_m100_7",   0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, SETTLE + 1};
    vecs[5] = '{"p1_min_1",    1, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, SETTLE + 1};
    vecs[6] = '{"p1_5_0",      1, 32'd5,          32'd0,          32'd0,          1'b1, 1};
    vecs[7] = '{"p0_7_m7",     0, 32'd7,          32'hFFFF_FFF9,  32'hFFFF_FFFF,  1'b0, SETTLE + 1};
    vecs[8] = '{"p0_3_5",      0, 32'd3,          32'd5,          32'd0,          1'b0, SETTLE + 1};
    for (int i = 0; i < 9; i++) begin
      run_one(vecs[i].nm, vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, vecs[i].lat);
    end

    // Contention from reset: port 0 first, then alternate, back-to-back issue.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 32'd100, 32'd10);
    set_req(1, 1'b1, 32'd9, 32'd3);
    nacc = 0;
    nresp = 0;
    for (int c = 0; c < 60 && nacc < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk_b("cont single_ready", req0_ready & req1_ready, 1'b0);
      if (resp0_valid && nresp < 4) begin resp_port[nresp] = 0; resp_q[nresp] = resp0_quotient; nresp++; end
      if (resp1_valid && nresp < 4) begin resp_port[nresp] = 1; resp_q[nresp] = resp1_quotient; nresp++; end
      if (req0_ready) begin acc_port[nacc] = 0; acc_cyc[nacc] = c; nacc++; end
      else if (req1_ready) begin acc_port[nacc] = 1; acc_cyc[nacc] = c; nacc++; end
    end
    chk_i("cont accepts", nacc, 3);
    chk_i("cont responses", nresp, 2);
    if (nacc == 3 && nresp == 2) begin
      chk_i("cont first_port", acc_port[0], 0);
      chk_i("cont second_port", acc_port[1], 1);
      chk_i("cont third_port", acc_port[2], 0);
      chk_i("cont interval", acc_cyc[1] - acc_cyc[0], SETTLE + 2);
      chk_i("cont interval2", acc_cyc[2] - acc_cyc[1], SETTLE + 2);
      chk_i("cont resp0_port", resp_port[0], 0);
      chk_w("cont resp0_q", resp_q[0], 32'd10);
      chk_i("cont resp1_port", resp_port[1], 1);
      chk_w("cont resp1_q", resp_q[1], 32'd3);
      $display("txn contention order=%0d,%0d,%0d q=%0d,%0d", acc_port[0], acc_port[1], acc_port[2],
               resp_q[0], resp_q[1]);
    end
    @(posedge clk);
    #1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    wait_idle("cont");

    // Backpressure on port 1 with port 0 waiting.
    @(negedge clk);
    resp1_ready = 1'b0;
    resp0_ready = 1'b1;
    set_req(1, 1'b1, 32'd21, 32'd7);
    #1;
    chk_b("bp req1_ready", req1_ready, 1'b1);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, '0, '0);
    set_req(0, 1'b1, 32'd50, 32'd5);
    wait_resp("bp p1", 1, cyc_n);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk_b("bp resp1_valid", resp1_valid, 1'b1);
      chk_w("bp resp1_q", resp1_quotient, 32'd3);
      chk_b("bp resp1_dbz", resp1_dbz, 1'b0);
      chk_b("bp req0_ready", req0_ready, 1'b0);
    end
    @(negedge clk);
    resp1_ready = 1'b1;
    #1;
    chk_b("bp handshake_no_accept", req0_ready, 1'b0);
    @(negedge clk);
    chk_b("bp resp1_dropped", resp1_valid, 1'b0);
    chk_b("bp req0_accept", req0_ready, 1'b1);
    $display("txn backpressure p1 q=3 then p0 accept=%b", req0_ready);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, '0, '0);
    wait_resp("bp p0", 0, cyc_n);
    chk_w("bp p0_q", resp0_quotient, 32'd10);
    wait_idle("bp");

    // Reset in the middle of SETTLE drops the operation.
    @(negedge clk);
    set_req(0, 1'b1, 32'd8, 32'd2);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_b("rst resp0_valid", resp0_valid, 1'b0);
    chk_w("rst resp0_q", resp0_quotient, 32'h0);
    chk_w("rst resp1_q", resp1_quotient, 32'h0);
    chk_w("rst div_dividend", div_dividend, 32'h0);
    chk_w("rst div_divisor", div_divisor, 32'h0);
    chk_b("rst busy", busy, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_b("rst no_resp", resp0_valid | resp1_valid, 1'b0);
    end
    $display("txn reset_mid_settle dropped");
    run_one("rst_reissue", 0, 32'd8, 32'd2, 32'd4, 1'b0, SETTLE + 1);

    // Randomized traffic against a latency-rule reference model.
    do_reset();
    m_busy = 1'b0; m_last = 1'b1; m_owner = 0; m_resp = 0;
    m_a = '0; m_b = '0; m_q = '0; m_dbz = 1'b0; txn = 0;
    for (int t = 0; t < 2500; t++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
        case ($urandom_range(0, 7))
          0:       rb = 32'd0;
          1:       rb = $urandom;
          default: rb = 32'($urandom_range(1, 20)) - 32'd10;
        endcase
        if (rb == 32'd0 && $urandom_range(0, 1) == 0) rb = 32'd3;
        if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
        set_req(q, ($urandom_range(0, 1) == 1), ra, rb);
      end
      resp0_ready = ($urandom_range(0, 9) < 6);
      resp1_ready = ($urandom_range(0, 9) < 6);
      #1;
      er0 = !m_busy && req0_valid && (!req1_valid || m_last);
      er1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      ev0 = m_busy && (t >= m_resp) && (m_owner == 0);
      ev1 = m_busy && (t >= m_resp) && (m_owner == 1);
      chk_b("rnd req0_ready", req0_ready, er0);
      chk_b("rnd req1_ready", req1_ready, er1);
      chk_b("rnd resp0_valid", resp0_valid, ev0);
      chk_b("rnd resp1_valid", resp1_valid, ev1);
      chk_b("rnd busy", busy, m_busy);
      if (m_busy) begin
        chk_w("rnd div_dividend", div_dividend, m_a);
        chk_w("rnd div_divisor", div_divisor, m_b);
      end
      if (ev0 || ev1) begin
        chk_w("rnd quotient", rq(m_owner), m_q);
        chk_b("rnd dbz", rd(m_owner), m_dbz);
      end
      if (er0 || er1) begin
        p = er1 ? 1 : 0;
        m_busy = 1'b1;
        m_owner = p;
        m_last = (p == 1);
        m_a = (p == 1) ? req1_dividend : req0_dividend;
        m_b = (p == 1) ? req1_divisor : req0_divisor;
        m_dbz = (m_b == 32'd0);
        m_q = m_dbz ? 32'd0 : 32'($signed(m_a) / $signed(m_b));
        m_resp = t + (m_dbz ? 1 : SETTLE + 1);
      end else if ((ev0 && resp0_ready) || (ev1 && resp1_ready)) begin
        m_busy = 1'b0;
        txn++;
        $display("txn rnd#%0d port=%0d %h/%h -> q=%h dbz=%b", txn, m_owner, m_a, m_b,
                 rq(m_owner), rd(m_owner));
      end
    end
    chk_b("rnd some_traffic", (txn > 50), 1'b1);

    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencer and arbiter that shares one combinational signed array divider between two requesters (calculator keypad path, port 0; expression engine, port 1).
- The divider is a long combinational ripple path, so the controller treats it as a multicycle path. It registers the operands, holds them stable for SETTLE cycles, then captures the quotient.
- Divide-by-zero is detected in the controller and never sent to the divider.

Parameters:
N, 32, operand/quotient width (two's complement)
SETTLE, 4, cycles the operands are held before the quotient is sampled (legal range >=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted when valid&ready
req0_dividend  in  N  port 0 dividend
req0_divisor  in  N  port 0 divisor
resp0_valid  out  1  port 0 result valid
resp0_ready  in  1  port 0 result consumed
resp0_quotient  out  N  port 0 quotient
resp0_dbz  out  1  port 0 divide-by-zero flag
req1_*, resp1_*  same as port 0, for port 1
div_dividend  out  N  operand to shared divider
div_divisor  out  N  operand to shared divider
div_quotient  in  N  quotient from shared divider
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SETTLE, RESP.
- Reset:
  - state=IDLE, all resp*_valid=0, resp*_quotient=0, resp*_dbz=0.
  - div_dividend=0, div_divisor=0, counter=0, owner=0, last_grant=1 (so port 0 wins the first contention).
- Reset mid-operation: the in-flight operation is dropped silently. No response is issued, and the requester must re-issue.
- Grant (combinational):
  - If only one reqX_valid is high, that port is granted.
  - If both are high, grant the port != last_grant.
  - reqX_ready = (state==IDLE) & grantX. Both readies are never high together. Ready is 0 in SETTLE and RESP.
- IDLE, on accept (valid&ready):
  - Latch dividend/divisor into div_dividend/div_divisor; owner=granted port; last_grant=granted port.
  - Divisor==0: go to RESP with quotient=0, dbz=1. The divider operands are still latched, but the result is ignored.
  - Otherwise: counter=SETTLE-1, go to SETTLE.
- SETTLE:
  - div_* held stable. If counter!=0, decrement.
  - If counter==0: capture div_quotient into the owner's quotient register, dbz=0, go to RESP.
- RESP:
  - resp_valid of owner =1; the other port's resp_valid =0. Quotient and dbz held stable until respX_ready.
  - On handshake, go to IDLE and drop resp_valid next cycle.
  - No new request is accepted in the handshake cycle.
- Latency (accept edge = cycle 0):
  - Normal: resp_valid high from cycle SETTLE+1.
  - Divide-by-zero: resp_valid high from cycle 1.
- Minimum issue interval: SETTLE+2 cycles normal, 2 cycles dbz.
- div_dividend/div_divisor change only on an accept edge. They stay constant through SETTLE and RESP, so multicycle constraints hold.
- Arithmetic: the quotient is passed through unmodified from the divider (signed, truncated toward zero). Overflow case (-2^(N-1))/(-1) is not special-cased; the result is whatever the divider produces, with dbz=0.
- Request inputs are sampled only on the accept edge. Changes while not ready are ignored.
- resp_ready while resp_valid is low is ignored.
- Outputs are registered except reqX_ready.

Test Plan:
- Port 0: 12/4, SETTLE=4, resp0_ready=1 -> req0_ready=1 at cycle 0; resp0_valid at cycle 5 with quotient=3, dbz=0; busy high cycles 1-5.
- Port 1: -7/2 (0xFFFFFFF9/0x00000002) -> resp1_quotient=0xFFFFFFFD, resp1_valid at cycle 5; resp0_valid stays 0 throughout.
- Both valid from reset: port 0 (100/10) and port 1 (9/3) held valid -> port 0 served first (q=10), then port 1 (q=3).
  - A third contention after that: port 0 again, alternating.
  - The second accept occurs exactly SETTLE+2 cycles after the first.
- Port 0: 55/0 -> resp0_valid at cycle 1, quotient=0, dbz=1; the divider result is never sampled.
- Backpressure: hold resp1_ready=0 for 10 cycles with a port 0 request pending -> resp1_valid, quotient and dbz are stable, req0_ready=0 throughout.
  - After resp1_ready=1, the next cycle is IDLE and port 0 is accepted.
- Reset during SETTLE (cycle 2 of 8/2): assert reset one cycle -> no resp_valid; all outputs at reset values.
  - A subsequent 8/2 returns 4 with normal latency.
